game_tick_scheduler: RTL and testbench
======================================

Name: game_tick_scheduler

Overview:
Sequences the snake game's timebase from MasterClock. It produces single-cycle GameTick enables whose period shrinks as the speed level rises, and a free-running ScanTick enable for seven-segment digit scanning. It also handles run, pause and single-step control. It sits between the top-level game FSM (Enable, pause/step/speed requests) and the movement/display logic that consumes the enables.

Parameters:
BASE_PERIOD, 50000000, GameTick period in MasterClock cycles at level 0
PERIOD_DEC, 4000000, period reduction per speed level
MIN_PERIOD, 10000000, lower clamp on game period; must be >= 2
MAX_LEVEL, 9, highest speed level; must be < 16
SCAN_PERIOD, 160000, ScanTick period in MasterClock cycles; must be >= 2
CNT_WIDTH, 26, width of period counters and the Period output

Ports:
MasterClock  in  1  system clock; all state updates on its posedge
ResetN  in  1  asynchronous active-low reset
Enable  in  1  level; high = game running, low = idle/cleared
PauseToggle  in  1  one-cycle pulse; toggles run/pause
StepReq  in  1  one-cycle pulse; request one GameTick while paused
SpeedUp  in  1  one-cycle pulse; level +1, saturating
SpeedReset  in  1  one-cycle pulse; level to 0
GameTick  out  1  one-cycle enable pulse for a game step
ScanTick  out  1  one-cycle enable pulse for display scan
Level  out  4  current speed level
Paused  out  1  high in PAUSED and STEP states
Period  out  CNT_WIDTH  active game period in cycles

Behaviour:
- Reset (ResetN low, asynchronous):
  - GameTick=0, ScanTick=0, Paused=0, Level=0, Period=BASE_PERIOD.
  - Both counters 0; state IDLE.
- Period is a registered value: max(BASE_PERIOD - Level*PERIOD_DEC, MIN_PERIOD), computed without underflow.
  - It updates the cycle after Level changes.
  - The game counter uses the new Period only at its next reload; the current interval is never shortened mid-count.
- Level:
  - SpeedUp increments Level, saturating at MAX_LEVEL.
  - SpeedReset sets Level to 0 and wins over a simultaneous SpeedUp.
  - Level changes in any state; Enable low does not clear it.
- State IDLE:
  - Game counter held at 0; GameTick=0; Paused=0.
  - Goes to RUN on the cycle Enable is sampled high.
- State RUN:
  - Game counter increments each cycle.
  - When the counter equals the latched period minus 1, GameTick=1 for one cycle, the counter reloads to 0, and the latched period takes the current Period.
  - First GameTick occurs exactly Period cycles after entering RUN.
  - PauseToggle moves to PAUSED. A tick due in that same cycle is still emitted.
  - StepReq is ignored.
- State PAUSED:
  - Counter frozen; GameTick=0; Paused=1.
  - PauseToggle returns to RUN, resuming from the frozen counter value.
  - StepReq moves to STEP.
  - If PauseToggle and StepReq arrive together, PauseToggle wins and the step is dropped.
- State STEP:
  - GameTick=1 for exactly one cycle; counter cleared to 0; Paused stays 1.
  - Unconditionally returns to PAUSED next cycle. Requests arriving during STEP are ignored.
- Enable low in any state: next state IDLE, counter cleared, no GameTick that cycle.
- ScanTick:
  - Independent counter, free-running from reset release regardless of state or Enable.
  - ScanTick=1 when the scan counter equals SCAN_PERIOD-1, then the counter wraps to 0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Both counters wrap only by reload and never overflow CNT_WIDTH.

Test Plan:
(Overrides for all scenarios: BASE_PERIOD=20, PERIOD_DEC=4, MIN_PERIOD=8, MAX_LEVEL=5, SCAN_PERIOD=3, CNT_WIDTH=8.)
1. Release reset, Enable=1 at cycle 10 -> GameTick pulses at cycles 30, 50, 70; ScanTick pulses every 3rd cycle from reset release; Paused=0, Level=0, Period=20.
2. Three SpeedUp pulses -> Level=3, Period=8 one cycle after the third pulse; the interval in progress completes at 20, subsequent ticks every 8 cycles. Three more pulses -> Level saturates at 5, Period stays 8 (clamped).
3. PauseToggle in RUN when the game counter = 7, hold 50 cycles -> Paused=1, no GameTick, counter stays 7. Second PauseToggle -> RUN; next tick when the counter reaches 19, i.e. 12 cycles later.
4. In PAUSED, StepReq -> exactly one GameTick the following cycle, counter=0, Paused=1 throughout. StepReq while in RUN -> no extra tick.
5. Simultaneous events:
   - PauseToggle+StepReq in PAUSED -> RUN, no step tick.
   - SpeedUp+SpeedReset -> Level=0, Period=20.
   - PauseToggle on the tick cycle -> tick emitted, then PAUSED.
6. Assert ResetN low mid-RUN at counter=13, asynchronously between clock edges -> all outputs 0 and Level=0 immediately; Period=20. After release with Enable=1 -> first tick 20 cycles after re-entering RUN.

Source files
------------

// File: rtl/game_tick_scheduler_if.sv
// Control and timebase bundle between the game FSM (master) and the tick scheduler (slave).
// The master issues run/pause/step/speed requests and consumes the tick enables and status.
interface game_tick_scheduler_if #(
   parameter int CNT_WIDTH = 26
);
   logic                 Enable;
   logic                 PauseToggle;
   logic                 StepReq;
   logic                 SpeedUp;
   logic                 SpeedReset;
   logic                 GameTick;
   logic                 ScanTick;
   logic [3:0]           Level;
   logic                 Paused;
   logic [CNT_WIDTH-1:0] Period;

   modport master (
      output Enable, PauseToggle, StepReq, SpeedUp, SpeedReset,
      input  GameTick, ScanTick, Level, Paused, Period
   );

   modport slave (
      input  Enable, PauseToggle, StepReq, SpeedUp, SpeedReset,
      output GameTick, ScanTick, Level, Paused, Period
   );
endinterface

// File: rtl/game_tick_scheduler.sv
// Game timebase: speed-dependent GameTick enables with run/pause/single-step control,
// plus a free-running ScanTick enable for display multiplexing. All outputs are registered.
module game_tick_scheduler #(
   parameter int BASE_PERIOD = 50000000,
   parameter int PERIOD_DEC  = 4000000,
   parameter int MIN_PERIOD  = 10000000,
   parameter int MAX_LEVEL   = 9,
   parameter int SCAN_PERIOD = 160000,
   parameter int CNT_WIDTH   = 26
) (
   input  logic                MasterClock,
   input  logic                ResetN,
   game_tick_scheduler_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] ZERO      = {CNT_WIDTH{1'b0}};
   localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] BASE_P    = CNT_WIDTH'(BASE_PERIOD);
   localparam logic [CNT_WIDTH-1:0] SCAN_LAST = CNT_WIDTH'(SCAN_PERIOD - 1);
   localparam logic [3:0]           MAX_LVL   = 4'(MAX_LEVEL);

   state_t               r_state;
   logic [3:0]           r_level;
   logic [CNT_WIDTH-1:0] r_period;
   logic [CNT_WIDTH-1:0] r_interval;
   logic [CNT_WIDTH-1:0] r_game_cnt;
   logic [CNT_WIDTH-1:0] r_scan_cnt;
   logic                 r_game_tick;
   logic                 r_scan_tick;
   logic                 r_paused;
   logic                 w_tick_due;

   // Wide arithmetic so that a large level never wraps below the clamp.
   function automatic logic [CNT_WIDTH-1:0] period_for_level(input logic [3:0] lvl);
      longint dec;
      dec = longint'(lvl) * longint'(PERIOD_DEC);
      if (dec >= longint'(BASE_PERIOD - MIN_PERIOD)) begin
         return CNT_WIDTH'(MIN_PERIOD);
      end else begin
         return CNT_WIDTH'(longint'(BASE_PERIOD) - dec);
      end
   endfunction

   assign w_tick_due = (r_game_cnt == (r_interval - ONE));

   // Speed level and the period derived from it one cycle later.
   always_ff @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) begin
         r_level  <= 4'd0;
         r_period <= BASE_P;
      end else begin
         r_period <= period_for_level(r_level);
         if (bus.SpeedReset) begin
            r_level <= 4'd0;
         end else if (bus.SpeedUp && (r_level < MAX_LVL)) begin
            r_level <= r_level + 4'd1;
         end else begin
            r_level <= r_level;
         end
      end
   end

   // Free-running scan divider, independent of game state.
   always_ff @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) begin
         r_scan_cnt  <= ZERO;
         r_scan_tick <= 1'b0;
      end else if (r_scan_cnt == SCAN_LAST) begin
         r_scan_cnt  <= ZERO;
         r_scan_tick <= 1'b1;
      end else begin
         r_scan_cnt  <= r_scan_cnt + ONE;
         r_scan_tick <= 1'b0;
      end
   end

   // Run/pause/step sequencer; r_interval holds the period of the interval in progress.
   always_ff @(posedge MasterClock or negedge ResetN) begin
      if (!ResetN) begin
         r_state     <= ST_IDLE;
         r_game_cnt  <= ZERO;
         r_interval  <= BASE_P;
         r_game_tick <= 1'b0;
         r_paused    <= 1'b0;
      end else if (!bus.Enable) begin
         r_state     <= ST_IDLE;
         r_game_cnt  <= ZERO;
         r_game_tick <= 1'b0;
         r_paused    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state     <= ST_RUN;
               r_game_cnt  <= ZERO;
               r_interval  <= r_period;
               r_game_tick <= 1'b0;
               r_paused    <= 1'b0;
            end
            ST_RUN: begin
               // A due tick is emitted even when a pause lands on the same cycle.
               if (w_tick_due) begin
                  r_game_tick <= 1'b1;
                  r_game_cnt  <= ZERO;
                  r_interval  <= r_period;
               end else begin
                  r_game_tick <= 1'b0;
                  if (!bus.PauseToggle) begin
                     r_game_cnt <= r_game_cnt + ONE;
                  end
               end
               if (bus.PauseToggle) begin
                  r_state  <= ST_PAUSED;
                  r_paused <= 1'b1;
               end else begin
                  r_paused <= 1'b0;
               end
            end
            ST_PAUSED: begin
               r_game_tick <= 1'b0;
               r_paused    <= 1'b1;
               if (bus.PauseToggle) begin
                  r_state  <= ST_RUN;
                  r_paused <= 1'b0;
               end else if (bus.StepReq) begin
                  r_state     <= ST_STEP;
                  r_game_tick <= 1'b1;
                  r_game_cnt  <= ZERO;
                  r_interval  <= r_period;
               end
            end
            ST_STEP: begin
               r_state     <= ST_PAUSED;
               r_game_tick <= 1'b0;
               r_paused    <= 1'b1;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_game_cnt  <= ZERO;
               r_game_tick <= 1'b0;
               r_paused    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.GameTick = r_game_tick;
   assign bus.ScanTick = r_scan_tick;
   assign bus.Level    = r_level;
   assign bus.Paused   = r_paused;
   assign bus.Period   = r_period;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Scoreboard bench for game_tick_scheduler: a driver steps a behavioural model per clock and
// queues the expected outputs; an independent monitor pops and compares after each edge.
module tb_game_tick_scheduler;

   localparam int BASE = 20;
   localparam int DEC  = 4;
   localparam int MINP = 8;
   localparam int MAXL = 5;
   localparam int SCAN = 3;
   localparam int W    = 8;

   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_PAUSED = 2;
   localparam int M_STEP   = 3;

   logic MasterClock = 1'b0;
   logic ResetN      = 1'b0;

   game_tick_scheduler_if #(.CNT_WIDTH(W)) bus ();

   game_tick_scheduler #(
      .BASE_PERIOD(BASE), .PERIOD_DEC(DEC), .MIN_PERIOD(MINP),
      .MAX_LEVEL(MAXL), .SCAN_PERIOD(SCAN), .CNT_WIDTH(W)
   ) dut (
      .MasterClock(MasterClock),
      .ResetN(ResetN),
      .bus(bus)
   );

   always #5 MasterClock = ~MasterClock;

   typedef struct {
      int tick;
      int scan;
      int paused;
      int level;
      int period;
   } exp_t;

   exp_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   // Model state: mode, speed, cycles still to count before the next tick, scan phase.
   int m_mode, m_level, m_period, m_due, m_interval, m_scan;

   function automatic int period_of(input int lvl);
      int p;
      p = BASE - lvl * DEC;
      return (p < MINP) ? MINP : p;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      n_tests++;
      if (act != expv) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_mode     = M_IDLE;
      m_level    = 0;
      m_period   = BASE;
      m_due      = BASE;
      m_interval = BASE;
      m_scan     = 0;
   endtask

   // Apply inputs for the coming edge and queue what the outputs must be after it.
   task automatic drive_step(input bit en, input bit pt, input bit st, input bit su, input bit sr);
      exp_t e;
      bus.Enable      = en;
      bus.PauseToggle = pt;
      bus.StepReq     = st;
      bus.SpeedUp     = su;
      bus.SpeedReset  = sr;
      e.scan = (m_scan == SCAN - 1) ? 1 : 0;
      m_scan = (e.scan == 1) ? 0 : m_scan + 1;
      e.tick = 0;
      if (!en) begin
         m_mode = M_IDLE;
      end else if (m_mode == M_IDLE) begin
         m_mode     = M_RUN;
         m_due      = m_period;
         m_interval = m_period;
      end else if (m_mode == M_RUN) begin
         if (m_due == 1) begin
            e.tick     = 1;
            m_due      = m_period;
            m_interval = m_period;
         end else if (!pt) begin
            m_due--;
         end
         if (pt) m_mode = M_PAUSED;
      end else if (m_mode == M_PAUSED) begin
         if (pt) begin
            m_mode = M_RUN;
         end else if (st) begin
            m_mode     = M_STEP;
            e.tick     = 1;
            m_due      = m_period;
            m_interval = m_period;
         end
      end else begin
         m_mode = M_PAUSED;
      end
      e.paused = (m_mode == M_PAUSED || m_mode == M_STEP) ? 1 : 0;
      m_period = period_of(m_level);
      if (sr) m_level = 0;
      else if (su && m_level < MAXL) m_level++;
      e.level  = m_level;
      e.period = m_period;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit en, input bit pt, input bit st, input bit su, input bit sr);
      @(negedge MasterClock);
      drive_step(en, pt, st, su, sr);
   endtask

   // Run until the game counter (cycles elapsed in the interval) equals target.
   task automatic run_until(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (m_mode == M_RUN && (m_interval - m_due) == target) return;
         cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      n_tests++;
      n_fail++;
      $display("FAIL run_until: counter %0d not reached within %0d cycles", target, budget);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge MasterClock);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("GameTick", int'(bus.GameTick), e.tick);
            check("ScanTick", int'(bus.ScanTick), e.scan);
            check("Paused",   int'(bus.Paused),   e.paused);
            check("Level",    int'(bus.Level),    e.level);
            check("Period",   int'(bus.Period),   e.period);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      bus.Enable = 1'b0; bus.PauseToggle = 1'b0; bus.StepReq = 1'b0;
      bus.SpeedUp = 1'b0; bus.SpeedReset = 1'b0;
      model_reset();
      #12;
      check("rst_GameTick", int'(bus.GameTick), 0);
      check("rst_ScanTick", int'(bus.ScanTick), 0);
      check("rst_Paused",   int'(bus.Paused),   0);
      check("rst_Level",    int'(bus.Level),    0);
      check("rst_Period",   int'(bus.Period),   BASE);

      @(negedge MasterClock);
      ResetN = 1'b1;
      drive_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (8) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (70) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Speed up mid-interval, then saturate.
      repeat (3) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         repeat (2) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      repeat (60) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Pause at counter 7, hold, resume.
      run_until(7, 100);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (50) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single steps while paused, then StepReq while running.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (4) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      repeat (25) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Simultaneous pause+step while paused resumes without a step tick.
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (3) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (25) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Pause arriving on the tick cycle.
      run_until(m_interval - 1, 100);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset mid-run with a non-zero level.
      run_until(0, 100);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      run_until(13, 100);
      @(negedge MasterClock);
      #2;
      ResetN = 1'b0;
      #1;
      check("arst_GameTick", int'(bus.GameTick), 0);
      check("arst_ScanTick", int'(bus.ScanTick), 0);
      check("arst_Paused",   int'(bus.Paused),   0);
      check("arst_Level",    int'(bus.Level),    0);
      check("arst_Period",   int'(bus.Period),   BASE);
      repeat (2) @(posedge MasterClock);
      @(negedge MasterClock);
      ResetN = 1'b1;
      model_reset();
      drive_step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (30) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized traffic.
      repeat (1500) begin
         cyc(($urandom_range(0, 39) != 0),
             ($urandom_range(0, 11) == 0),
             ($urandom_range(0, 5)  == 0),
             ($urandom_range(0, 9)  == 0),
             ($urandom_range(0, 29) == 0));
      end
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      repeat (2) @(posedge MasterClock);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
